// File: rtl/register_shift_seq.sv
// Sequenced shift/rotate register: parallel load plus a multi-step SHL/SHR/ROL/ROR engine.
// Defining REG_SHIFT_PARITY_EN adds a registered even-parity output of Q.
module register_shift_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             busy,
`ifdef REG_SHIFT_PARITY_EN
  output logic             parity,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_e           state_q;
  logic [AMT_W-1:0] count_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             serialOut_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] stepData_d;
  logic             stepBit_d;
  logic [WIDTH-1:0] dataNext_d;

  // One single-bit step of the captured operation; fill bit is sampled live.
  always_comb begin
    stepData_d = data_q;
    stepBit_d  = 1'b0;
    case (op_q)
      OP_SHL: begin
        stepData_d = {data_q[WIDTH-2:0], serial_in};
        stepBit_d  = data_q[WIDTH-1];
      end
      OP_SHR: begin
        stepData_d = {serial_in, data_q[WIDTH-1:1]};
        stepBit_d  = data_q[0];
      end
      OP_ROL: begin
        stepData_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        stepBit_d  = data_q[WIDTH-1];
      end
      OP_ROR: begin
        stepData_d = {data_q[0], data_q[WIDTH-1:1]};
        stepBit_d  = data_q[0];
      end
      default: begin
        stepData_d = data_q;
        stepBit_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    dataNext_d = data_q;
    if (load) begin
      dataNext_d = D;
    end else if (state_q == SHIFT && count_q != '0) begin
      dataNext_d = stepData_d;
    end
  end

  // Load overrides everything but reset, and abandons any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      op_q        <= OP_SHL;
      data_q      <= '0;
      serialOut_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (load) begin
      data_q  <= dataNext_d;
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q <= dataNext_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            count_q <= amount;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_q != '0) begin
            serialOut_q <= stepBit_d;
            count_q     <= count_q - AMT_W'(1);
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef REG_SHIFT_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^dataNext_d;
    end
  end

  assign parity = parity_q;
`endif

  assign Q          = data_q;
  assign serial_out = serialOut_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
